// File: rtl/uart_tx_frame_param.sv
// Parametrised UART transmitter: configurable data width, parity, stop bits and baud divisor.
// Valid/ready handshake; a word accepted in the final stop cycle starts the next frame with
// no idle gap.
module uart_tx_frame_param #(
  parameter int unsigned P_DATA_BITS     = 8,
  parameter int unsigned P_CLKS_PER_BAUD = 868,
  parameter int unsigned P_PARITY        = 0,
  parameter int unsigned P_STOP_BITS     = 1
) (
  input  logic                   i_CLK,
  input  logic                   i_RESET_N,
  input  logic                   i_TX_VALID,
  input  logic [P_DATA_BITS-1:0] i_DATA_IN,
  output logic                   o_TX_READY,
  output logic                   o_TX_BUSY,
  output logic                   o_TX,
  output logic                   o_TX_DONE
);

  // Guarded widths so an illegal parameter reports its own error, not a zero-width one.
  localparam int unsigned BaudW = (P_CLKS_PER_BAUD > 1) ? $clog2(P_CLKS_PER_BAUD) : 1;
  localparam int unsigned BitW  = (P_DATA_BITS > 1) ? $clog2(P_DATA_BITS) : 1;

  localparam logic [BaudW-1:0] BaudLast  = BaudW'(P_CLKS_PER_BAUD - 1);
  localparam logic [BitW-1:0]  DataLast  = BitW'(P_DATA_BITS - 1);
  localparam logic [BitW-1:0]  StopLast  = BitW'(P_STOP_BITS - 1);
  localparam bit               HasParity = (P_PARITY != 0);
  localparam bit               OddParity = (P_PARITY == 1);

  if (P_DATA_BITS < 5 || P_DATA_BITS > 9) begin : gen_chk_data_bits
    $error("uart_tx_frame_param: P_DATA_BITS must be 5..9");
  end
  if (P_CLKS_PER_BAUD < 2) begin : gen_chk_clks
    $error("uart_tx_frame_param: P_CLKS_PER_BAUD must be >= 2");
  end
  if (P_PARITY > 2) begin : gen_chk_parity
    $error("uart_tx_frame_param: P_PARITY must be 0, 1 or 2");
  end
  if (P_STOP_BITS < 1 || P_STOP_BITS > 2) begin : gen_chk_stop
    $error("uart_tx_frame_param: P_STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                 state_q, state_d;
  logic [BaudW-1:0]       baud_q, baud_d;
  logic [BitW-1:0]        bit_q, bit_d;      // data bit index, reused as stop bit index
  logic [P_DATA_BITS-1:0] shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;

  logic baud_end, last_stop, ready, accept;

  assign baud_end  = (baud_q == BaudLast);
  assign last_stop = (bit_q == StopLast);
  assign ready     = (state_q == StIdle) || ((state_q == StStop) && baud_end && last_stop);
  assign accept    = i_TX_VALID && ready;

  // Next-state, baud/bit counting and the registered line value for the coming cycle.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    done_d   = 1'b0;

    if (state_q != StIdle) begin
      baud_d = baud_end ? '0 : baud_q + BaudW'(1);
    end

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
      end
      StStart: begin
        if (baud_end) begin
          state_d = StData;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (baud_end) begin
          if (bit_q == DataLast) begin
            bit_d = '0;
            if (HasParity) begin
              state_d = StParity;
              tx_d    = parity_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BitW'(1);
            shift_d = {1'b0, shift_q[P_DATA_BITS-1:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      StParity: begin
        if (baud_end) begin
          state_d = StStop;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      StStop: begin
        if (baud_end) begin
          if (last_stop) begin
            state_d = StIdle;
            bit_d   = '0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    // An accept overrides everything except the done pulse of the frame just finishing.
    if (accept) begin
      state_d  = StStart;
      baud_d   = '0;
      bit_d    = '0;
      shift_d  = i_DATA_IN;
      parity_d = (^i_DATA_IN) ^ OddParity;
      tx_d     = 1'b0;
    end
  end

  // State register with synchronous active-low reset; reset aborts any frame in flight.
  always_ff @(posedge i_CLK) begin
    if (!i_RESET_N) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

  assign o_TX_READY = ready;
  assign o_TX_BUSY  = (state_q != StIdle);
  assign o_TX       = tx_q;
  assign o_TX_DONE  = done_q;

`ifdef FORMAL
  a_idle_high: assert property (@(posedge i_CLK) disable iff (!i_RESET_N)
      !o_TX_BUSY |-> o_TX);
  a_ready_busy: assert property (@(posedge i_CLK) disable iff (!i_RESET_N)
      (o_TX_READY && o_TX_BUSY) |-> ((state_q == StStop) && baud_end && last_stop));
  a_bit_range: assert property (@(posedge i_CLK) disable iff (!i_RESET_N)
      bit_q <= DataLast);
  c_back_to_back: cover property (@(posedge i_CLK) disable iff (!i_RESET_N)
      o_TX_DONE && o_TX_BUSY && !o_TX);
`endif

endmodule

// File: tb/tb_uart_tx_frame_param.sv
// Bench for uart_tx_frame_param: five instances covering 8N1, 8E1, 8O1, 8N2 and 7O1.
// Expected line values come from a frame-level model (bit index = cycle / clks_per_baud).
module tb_uart_tx_frame_param;

  localparam int NumDut = 5;

  int cfg_clks [NumDut] = '{4, 4, 4, 4, 3};
  int cfg_bits [NumDut] = '{8, 8, 8, 8, 7};
  int cfg_par  [NumDut] = '{0, 2, 1, 0, 1};
  int cfg_stop [NumDut] = '{1, 1, 1, 2, 1};

  logic              clk;
  logic              rst_n;
  logic [NumDut-1:0] valid;
  logic [8:0]        data [NumDut];
  logic [NumDut-1:0] tx, ready, busy, done;

  int total = 0;
  int bad   = 0;

  uart_tx_frame_param #(.P_DATA_BITS(8), .P_CLKS_PER_BAUD(4), .P_PARITY(0), .P_STOP_BITS(1))
    u_8n1 (.i_CLK(clk), .i_RESET_N(rst_n), .i_TX_VALID(valid[0]), .i_DATA_IN(data[0][7:0]),
           .o_TX_READY(ready[0]), .o_TX_BUSY(busy[0]), .o_TX(tx[0]), .o_TX_DONE(done[0]));
  uart_tx_frame_param #(.P_DATA_BITS(8), .P_CLKS_PER_BAUD(4), .P_PARITY(2), .P_STOP_BITS(1))
    u_8e1 (.i_CLK(clk), .i_RESET_N(rst_n), .i_TX_VALID(valid[1]), .i_DATA_IN(data[1][7:0]),
           .o_TX_READY(ready[1]), .o_TX_BUSY(busy[1]), .o_TX(tx[1]), .o_TX_DONE(done[1]));
  uart_tx_frame_param #(.P_DATA_BITS(8), .P_CLKS_PER_BAUD(4), .P_PARITY(1), .P_STOP_BITS(1))
    u_8o1 (.i_CLK(clk), .i_RESET_N(rst_n), .i_TX_VALID(valid[2]), .i_DATA_IN(data[2][7:0]),
           .o_TX_READY(ready[2]), .o_TX_BUSY(busy[2]), .o_TX(tx[2]), .o_TX_DONE(done[2]));
  uart_tx_frame_param #(.P_DATA_BITS(8), .P_CLKS_PER_BAUD(4), .P_PARITY(0), .P_STOP_BITS(2))
    u_8n2 (.i_CLK(clk), .i_RESET_N(rst_n), .i_TX_VALID(valid[3]), .i_DATA_IN(data[3][7:0]),
           .o_TX_READY(ready[3]), .o_TX_BUSY(busy[3]), .o_TX(tx[3]), .o_TX_DONE(done[3]));
  uart_tx_frame_param #(.P_DATA_BITS(7), .P_CLKS_PER_BAUD(3), .P_PARITY(1), .P_STOP_BITS(1))
    u_7o1 (.i_CLK(clk), .i_RESET_N(rst_n), .i_TX_VALID(valid[4]), .i_DATA_IN(data[4][6:0]),
           .o_TX_READY(ready[4]), .o_TX_BUSY(busy[4]), .o_TX(tx[4]), .o_TX_DONE(done[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Frame length in clocks from the frame-format rule.
  function automatic int frame_len(input int k);
    return cfg_clks[k] * (1 + cfg_bits[k] + ((cfg_par[k] != 0) ? 1 : 0) + cfg_stop[k]);
  endfunction

  // Line value for bit slot idx of a frame carrying word w: start, data LSB first, parity, stops.
  function automatic logic exp_bit(input int k, input logic [8:0] w, input int idx);
    int   n = cfg_bits[k];
    logic x = 1'b0;
    for (int i = 0; i < n; i++) x = x ^ w[i];
    if (idx == 0) return 1'b0;
    if (idx <= n) return w[idx-1];
    if (cfg_par[k] != 0 && idx == n + 1) return (cfg_par[k] == 1) ? ~x : x;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one word on instance k from idle and checks every cycle of the frame plus the done pulse.
  task automatic run_frame(input int k, input logic [8:0] w, input logic [8:0] alt,
                           input bit rand_data);
    int len = frame_len(k);
    int cb  = cfg_clks[k];
    logic e;
    total++;
    if (ready[k] !== 1'b1) begin
      bad++;
      $display("FAIL ready_before_send k=%0d got=%b want=1", k, ready[k]);
    end
    valid[k] = 1'b1;
    data[k]  = w;
    tick();
    valid[k] = 1'b0;
    data[k]  = alt;
    for (int c = 1; c <= len; c++) begin
      if (rand_data) data[k] = 9'($urandom);
      e = exp_bit(k, w, (c - 1) / cb);
      total += 4;
      if (tx[k] !== e) begin
        bad++;
        $display("FAIL frame_tx k=%0d w=%h cycle=%0d got=%b want=%b", k, w, c, tx[k], e);
      end
      if (busy[k] !== 1'b1) begin
        bad++;
        $display("FAIL frame_busy k=%0d cycle=%0d got=%b want=1", k, c, busy[k]);
      end
      if (done[k] !== 1'b0) begin
        bad++;
        $display("FAIL frame_done_early k=%0d cycle=%0d got=%b want=0", k, c, done[k]);
      end
      if (ready[k] !== (c == len)) begin
        bad++;
        $display("FAIL frame_ready k=%0d cycle=%0d got=%b want=%b", k, c, ready[k], c == len);
      end
      tick();
    end
    total += 4;
    if (done[k] !== 1'b1) begin
      bad++;
      $display("FAIL done_pulse k=%0d cycle=%0d got=%b want=1", k, len + 1, done[k]);
    end
    if (busy[k] !== 1'b0) begin
      bad++;
      $display("FAIL busy_after k=%0d got=%b want=0", k, busy[k]);
    end
    if (tx[k] !== 1'b1) begin
      bad++;
      $display("FAIL tx_after k=%0d got=%b want=1", k, tx[k]);
    end
    if (ready[k] !== 1'b1) begin
      bad++;
      $display("FAIL ready_after k=%0d got=%b want=1", k, ready[k]);
    end
    tick();
    total++;
    if (done[k] !== 1'b0) begin
      bad++;
      $display("FAIL done_width k=%0d got=%b want=0", k, done[k]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = '0;
    for (int k = 0; k < NumDut; k++) data[k] = '0;
    tick();
    tick();
    for (int k = 0; k < NumDut; k++) begin
      total += 4;
      if (tx[k] !== 1'b1)    begin bad++; $display("FAIL reset_tx k=%0d got=%b want=1", k, tx[k]); end
      if (ready[k] !== 1'b1) begin bad++; $display("FAIL reset_ready k=%0d got=%b want=1", k, ready[k]); end
      if (busy[k] !== 1'b0)  begin bad++; $display("FAIL reset_busy k=%0d got=%b want=0", k, busy[k]); end
      if (done[k] !== 1'b0)  begin bad++; $display("FAIL reset_done k=%0d got=%b want=0", k, done[k]); end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    run_frame(0, 9'h0A5, 9'h0A5, 1'b0);
    run_frame(1, 9'h007, 9'h007, 1'b0);
    run_frame(2, 9'h007, 9'h007, 1'b0);
    run_frame(4, 9'h041, 9'h041, 1'b0);
  endtask

  task automatic test_data_change();
    run_frame(0, 9'h055, 9'h0AA, 1'b0);
  endtask

  task automatic test_back_to_back();
    int k = 3;
    int len = frame_len(3);
    int accepts = 0;
    logic [8:0] w;
    logic e;
    valid[k] = 1'b1;
    data[k]  = 9'h000;
    tick();
    data[k] = 9'h0FF;
    for (int c = 1; c <= 2 * len; c++) begin
      w = (c <= len) ? 9'h000 : 9'h0FF;
      e = exp_bit(k, w, ((c - 1) % len) / cfg_clks[k]);
      if (ready[k] && valid[k]) accepts++;
      total += 4;
      if (tx[k] !== e) begin
        bad++;
        $display("FAIL b2b_tx cycle=%0d got=%b want=%b", c, tx[k], e);
      end
      if (busy[k] !== 1'b1) begin
        bad++;
        $display("FAIL b2b_busy cycle=%0d got=%b want=1", c, busy[k]);
      end
      if (done[k] !== (c == len + 1)) begin
        bad++;
        $display("FAIL b2b_done cycle=%0d got=%b want=%b", c, done[k], c == len + 1);
      end
      if (ready[k] !== (c == len || c == 2 * len)) begin
        bad++;
        $display("FAIL b2b_ready cycle=%0d got=%b want=%b", c, ready[k],
                 (c == len || c == 2 * len));
      end
      if (c == len + 1) valid[k] = 1'b0;
      tick();
    end
    total += 3;
    if (accepts !== 1) begin
      bad++;
      $display("FAIL b2b_accepts got=%0d want=1 (after the first)", accepts);
    end
    if (done[k] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_done2 got=%b want=1", done[k]);
    end
    if (busy[k] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_busy_end got=%b want=0", busy[k]);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int k = 0;
    int cb = cfg_clks[0];
    logic e;
    valid[k] = 1'b1;
    data[k]  = 9'h03C;
    tick();
    valid[k] = 1'b0;
    // Run into the second cycle of data bit 3 (bit slot 4).
    for (int c = 1; c < 4 * cb + 2; c++) tick();
    e = exp_bit(k, 9'h03C, 4);
    total++;
    if (tx[k] !== e) begin
      bad++;
      $display("FAIL abort_pre_tx got=%b want=%b", tx[k], e);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total += 4;
    if (tx[k] !== 1'b1)    begin bad++; $display("FAIL abort_tx got=%b want=1", tx[k]); end
    if (ready[k] !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", ready[k]); end
    if (busy[k] !== 1'b0)  begin bad++; $display("FAIL abort_busy got=%b want=0", busy[k]); end
    if (done[k] !== 1'b0)  begin bad++; $display("FAIL abort_done got=%b want=0", done[k]); end
    for (int c = 0; c < frame_len(k); c++) begin
      tick();
      total++;
      if (done[k] !== 1'b0 || tx[k] !== 1'b1) begin
        bad++;
        $display("FAIL abort_quiet cycle=%0d got done=%b tx=%b want done=0 tx=1", c, done[k], tx[k]);
      end
    end
    run_frame(0, 9'h03C, 9'h03C, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      int k = $urandom_range(0, NumDut - 1);
      logic [8:0] w = 9'($urandom) & ((9'h1 << cfg_bits[k]) - 9'h1);
      int gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        total++;
        if (tx[k] !== 1'b1 || busy[k] !== 1'b0 || ready[k] !== 1'b1) begin
          bad++;
          $display("FAIL idle_gap k=%0d got tx=%b busy=%b ready=%b want 1,0,1", k, tx[k], busy[k],
                   ready[k]);
        end
        tick();
      end
      run_frame(k, w, 9'($urandom), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_data_change();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_param.md
Name: uart_tx_frame_param

Overview:
Parametrised UART transmitter, next generation of the team's fixed 8N1 transmitter. Data width, parity mode, stop-bit count and baud divisor are all configurable. A valid/ready handshake replaces the level enable, and back-to-back frames go out with no idle gap. It sits between a byte-stream source (FIFO or CSR) and the board TX pin.

Parameters:
P_DATA_BITS, 8, data bits per frame; legal 5..9.
P_CLKS_PER_BAUD, 868, clocks per bit period; legal >= 2 (868 = 100 MHz / 115200).
P_PARITY, 0, 0 = none, 1 = odd, 2 = even.
P_STOP_BITS, 1, stop bits per frame; legal 1 or 2.

Ports:
i_CLK  input  1  system clock; all logic on rising edge.
i_RESET_N  input  1  synchronous, active-low reset.
i_TX_VALID  input  1  source has a word to send.
i_DATA_IN  input  P_DATA_BITS  word to send; sampled only on an accept.
o_TX_READY  output  1  block can accept a word this cycle.
o_TX_BUSY  output  1  frame in progress (start through last stop bit).
o_TX  output  1  serial line, idle high; registered.
o_TX_DONE  output  1  one-cycle pulse at completion of a frame.

Behaviour:
- Reset (i_RESET_N low at a rising edge), effective next cycle:
  - o_TX=1, o_TX_READY=1, o_TX_BUSY=0, o_TX_DONE=0.
  - State IDLE; baud counter, bit counter and shift register cleared.
- Reset mid-frame aborts the frame immediately: o_TX returns high at the next edge and no o_TX_DONE pulse is issued.
- Accept: occurs at a rising edge where i_TX_VALID && o_TX_READY.
  - i_DATA_IN is latched into the shift register on that edge.
  - i_DATA_IN is ignored at all other times, including changes while busy.
- Latency: o_TX=0 (start bit) and o_TX_BUSY=1 in the cycle after accept.
- Baud counter: 0..P_CLKS_PER_BAUD-1, width $clog2(P_CLKS_PER_BAUD).
  - Cleared on accept, so each frame is aligned to its own start; not free-running.
  - A bit ends when the counter reaches P_CLKS_PER_BAUD-1; every bit, including parity and stop, lasts exactly P_CLKS_PER_BAUD cycles.
- States:
  - IDLE -> START on accept.
  - START -> DATA at end of bit.
  - DATA: P_DATA_BITS bits, LSB first. On the last bit, go to PARITY if P_PARITY != 0, else STOP.
  - PARITY -> STOP at end of bit.
  - STOP: P_STOP_BITS bit periods of o_TX=1, then IDLE, or START if an accept happened in the final cycle.
- Parity bit:
  - even: XOR of all data bits.
  - odd: inverted XOR of all data bits.
  - Computed from the latched word, never from the live i_DATA_IN.
- o_TX_READY:
  - 1 in IDLE.
  - 1 in the final clock of the last stop bit.
  - 0 otherwise.
- Back-to-back: an accept in the final stop cycle puts the next start bit on o_TX the following cycle; o_TX_BUSY stays 1 throughout.
- o_TX_DONE: high for exactly the cycle after the last stop-bit cycle, once per completed frame.
- Frame length in cycles: P_CLKS_PER_BAUD * (1 + P_DATA_BITS + (P_PARITY != 0) + P_STOP_BITS).
- Illegal parameter values must be flagged at elaboration (generate-time error); no runtime behaviour is defined for them.
- Formal build (FORMAL define):
  - o_TX=1 whenever not busy.
  - o_TX_READY && o_TX_BUSY only in the final stop cycle.
  - Bit counter never exceeds P_DATA_BITS-1.
  - Cover two consecutive frames with zero gap.

Test Plan:
- Send 0xA5 with P_CLKS_PER_BAUD=4, 8N1 -> o_TX = 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles; busy for 40 cycles; one o_TX_DONE pulse at cycle 41 after accept.
- Send 0x07 with P_PARITY=2 (even), then P_PARITY=1 (odd), CLKS=4 -> parity bit 1 for even, 0 for odd; frame 44 cycles.
- Send 0x00 then 0xFF with 8N2, CLKS=4, i_TX_VALID held high -> exactly two accepts; frames 44+44 cycles with no idle cycle between; o_TX_BUSY continuously 1 for 88 cycles; two done pulses.
- Drive i_RESET_N low for 1 cycle during data bit 3 of 0x3C -> o_TX=1, READY=1, BUSY=0 next cycle; no o_TX_DONE; next frame transmits correctly.
- Change i_DATA_IN from 0x55 to 0xAA after the accept of 0x55 -> transmitted bits match 0x55.
- P_DATA_BITS=7, P_PARITY=1, CLKS=3, send 0x41 -> data 1,0,0,0,0,0,1; parity bit 1; frame 30 cycles.
